// File: rtl/instr_loader.sv
// Instruction image loader: assembles a host byte stream (length, words, checksum)
// into instruction words, writes them from address 0, and releases the CPU once verified.
module instr_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 run,
  output logic                 error
);

  localparam int BYTES  = WORD_SIZE / 8;
  localparam int BCNT_W = $clog2(BYTES);
  localparam int CMP_W  = WORD_SIZE + ADDR_SIZE + 1;
  localparam logic [CMP_W-1:0]  MEM_DEPTH_W = CMP_W'(1) << ADDR_SIZE;
  localparam logic [BCNT_W-1:0] LAST_BYTE   = BCNT_W'(BYTES - 1);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERROR} state_t;

  state_t                 state, state_next;
  logic [BCNT_W-1:0]      byte_cnt;
  logic [WORD_SIZE-9:0]   shift_lo;
  logic [WORD_SIZE-1:0]   word_next;
  logic [WORD_SIZE-1:0]   len;
  logic [ADDR_SIZE:0]     word_cnt;
  logic [7:0]             checksum;
  logic                   accept, word_done, last_word;

  // The byte being accepted completes the word combinationally, so decisions
  // on the length and the write data need no extra cycle.
  assign word_next = {shift_lo, in_data};
  assign in_ready  = reset_n && (state == S_LEN || state == S_DATA || state == S_CHK);
  assign accept    = in_valid && in_ready;
  assign word_done = accept && (state == S_LEN || state == S_DATA) && (byte_cnt == LAST_BYTE);
  assign last_word = (CMP_W'(word_cnt) + CMP_W'(1)) == CMP_W'(len);
  assign run       = (state == S_DONE);
  assign error     = (state == S_ERROR);

  // NOTE: next state gets its default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_LEN: begin
        if (word_done) begin
          if (word_next == '0)                       state_next = S_CHK;
          else if (CMP_W'(word_next) > MEM_DEPTH_W)  state_next = S_ERROR;
          else                                       state_next = S_DATA;
        end
      end
      S_DATA:  if (word_done && last_word) state_next = S_CHK;
      S_CHK:   if (accept) state_next = (in_data == checksum) ? S_DONE : S_ERROR;
      default: state_next = state;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_LEN;
      byte_cnt <= '0;
      shift_lo <= '0;
      len      <= '0;
      word_cnt <= '0;
      checksum <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state <= state_next;
      wr_en <= 1'b0;
      if (accept && state != S_CHK) begin
        checksum <= checksum + in_data;
        shift_lo <= word_next[WORD_SIZE-9:0];
        byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      end
      if (word_done && state == S_LEN) len <= word_next;
      if (word_done && state == S_DATA) begin
        wr_en    <= 1'b1;
        wr_addr  <= word_cnt[ADDR_SIZE-1:0];
        wr_data  <= word_next;
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as the stream is
// built and popped by a monitor whenever wr_en is seen.
module tb_instr_loader;

  localparam int W = 16;
  localparam int A = 8;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         run;
  logic         error;

  int  n_compared   = 0;
  int  n_mismatched = 0;
  wr_t exp_q[$];

  instr_loader #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: every observed strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL write_unexpected: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_mismatched++;
          $display("FAIL write_value: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  // Tasks below start and end aligned to a negedge; inputs change there.
  task automatic send_stream(input logic [7:0] bytes[$], input int gap);
    for (int i = 0; i < bytes.size(); i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      @(negedge clk);
      if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'hxx;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_nominal();
    exp_q.push_back('{addr: 8'h00, data: 16'h1234});
    exp_q.push_back('{addr: 8'h01, data: 16'hABCD});
  endtask

  task automatic check_end(input string name, input logic exp_run, input logic exp_err);
    #1;
    n_compared++;
    if ({run, error, in_ready} !== {exp_run, exp_err, 1'b0}) begin
      n_mismatched++;
      $display("FAIL %s_status: got run=%b error=%b in_ready=%b, expected run=%b error=%b in_ready=0",
               name, run, error, in_ready, exp_run, exp_err);
    end
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL %s_writes: got %0d writes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    #1;
    n_compared++;
    if ({wr_en, wr_addr, wr_data, run, error, in_ready} !== '0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0h data=%0h run=%b error=%b in_ready=%b, expected all 0",
               wr_en, wr_addr, wr_data, run, error, in_ready);
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_ready: got in_ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    push_nominal();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 0);
    check_end("nominal", 1'b1, 1'b0);
  endtask

  task automatic test_bad_checksum();
    do_reset();
    push_nominal();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1}, 0);
    check_end("bad_checksum", 1'b0, 1'b1);
  endtask

  task automatic test_oversize();
    do_reset();
    send_stream('{8'h01, 8'h01}, 0);
    check_end("oversize", 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_end("oversize_hold", 1'b0, 1'b1);
  endtask

  task automatic test_empty();
    do_reset();
    send_stream('{8'h00, 8'h00, 8'h00}, 0);
    check_end("empty", 1'b1, 1'b0);
  endtask

  task automatic test_gaps();
    logic [7:0] s[$];
    do_reset();
    push_nominal();
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    for (int i = 0; i < s.size(); i++) begin
      send_stream('{s[i]}, 3);
      #1;
      n_compared++;
      if ({in_ready, run, error} !== 3'b100) begin
        n_mismatched++;
        $display("FAIL gaps_idle_%0d: got in_ready=%b run=%b error=%b, expected 1 0 0", i, in_ready, run, error);
      end
    end
    @(negedge clk);
    send_stream('{8'hC0}, 0);
    check_end("gaps", 1'b1, 1'b0);
  endtask

  task automatic test_max_length();
    logic [7:0] s[$];
    logic [7:0] sum;
    logic [W-1:0] w;
    do_reset();
    s = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      w = {8'(i) ^ 8'h5A, 8'(i)};
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
      exp_q.push_back('{addr: 8'(i), data: w});
    end
    sum = '0;
    foreach (s[i]) sum = sum + s[i];
    s.push_back(sum);
    send_stream(s, 0);
    check_end("max_length", 1'b1, 1'b0);
    n_compared++;
    if (wr_addr !== 8'hFF) begin
      n_mismatched++;
      $display("FAIL max_length_addr: got wr_addr=%0h, expected ff", wr_addr);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    exp_q.push_back('{addr: 8'h00, data: 16'h1234});
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34}, 0);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    n_compared++;
    if ({wr_en, wr_addr, wr_data, run, error, in_ready} !== '0 || exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL midload_reset: got wr_en=%b addr=%0h data=%0h run=%b error=%b in_ready=%b pending=%0d, expected all 0",
               wr_en, wr_addr, wr_data, run, error, in_ready, exp_q.size());
    end
    reset_n = 1'b1;
    @(negedge clk);
    push_nominal();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 0);
    check_end("midload_reload", 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_compared++;
      if ({in_ready, run} !== 2'b01) begin
        n_mismatched++;
        $display("FAIL done_offer_%0d: got in_ready=%b run=%b, expected 0 1", i, in_ready, run);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_oversize();
    test_empty();
    test_gaps();
    test_max_length();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
